pc_fetch: RTL

- Instruction fetch stage that sits directly upstream of the ALU/execute stage.
- Holds the program counter (PC) and presents the fetched instruction with a valid flag to decode/execute.
- Consumes the ALU's branch-compare result (jump) to redirect the PC, inserting a one-cycle bubble on a taken jump.
- Provides run/halt control and a cycle counter for the emulator harness.

---
 rtl/pc_fetch_if.sv | 38 +++
 rtl/pc_fetch.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus between pc_fetch and its harness: control in, PC/instruction out.
// jump_count exists only when PC_FETCH_JUMP_CNT_EN is defined.
interface pc_fetch_if #(
   parameter int pc_width   = 10,
   parameter int inst_width = 9,
   parameter int cnt_width  = 16
);
   logic                  start;
   logic                  stall;
   logic                  jump;
   logic [pc_width-1:0]   jump_target;
   logic                  halt_req;
   logic [inst_width-1:0] inst_mem_data;
   logic [pc_width-1:0]   pc;
   logic [inst_width-1:0] inst_out;
   logic                  inst_valid;
   logic                  halted;
   logic [cnt_width-1:0]  cycle_count;
`ifdef PC_FETCH_JUMP_CNT_EN
   logic [7:0]            jump_count;
`endif

   modport master (
      output start, stall, jump, jump_target, halt_req, inst_mem_data,
`ifdef PC_FETCH_JUMP_CNT_EN
      input  jump_count,
`endif
      input  pc, inst_out, inst_valid, halted, cycle_count
   );

   modport slave (
      input  start, stall, jump, jump_target, halt_req, inst_mem_data,
`ifdef PC_FETCH_JUMP_CNT_EN
      output jump_count,
`endif
      output pc, inst_out, inst_valid, halted, cycle_count
   );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC, registered instruction, taken-jump bubble, run/halt, cycle counter.
// Define PC_FETCH_JUMP_CNT_EN to add an 8-bit saturating count of accepted jumps.
module pc_fetch #(
   parameter int pc_width   = 10,
   parameter int inst_width = 9,
   parameter int start_addr = 0,
   parameter int cnt_width  = 16
) (
   input logic         clk,
   input logic         reset,
   pc_fetch_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

   localparam logic [pc_width-1:0] LP_START = pc_width'(start_addr);

   state_t                r_state, w_state;
   logic [pc_width-1:0]   r_pc, w_pc;
   logic [inst_width-1:0] r_inst, w_inst;
   logic                  r_vld, w_vld;
   logic [cnt_width-1:0]  r_cnt;
   logic                  w_fetch, w_jump_acc, w_counting;

   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_inst     = r_inst;
      w_vld      = r_vld;
      w_fetch    = 1'b0;
      w_jump_acc = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start) w_state = S_RUN;
         S_RUN: begin
            if (bus.halt_req) begin
               w_state = S_HALT;
               w_vld   = 1'b0;
            end else if (bus.jump && r_vld) begin
               // redirect beats stall; the bubble is the FLUSH cycle
               w_state    = S_FLUSH;
               w_pc       = bus.jump_target;
               w_vld      = 1'b0;
               w_jump_acc = 1'b1;
            end else if (!bus.stall) begin
               w_fetch = 1'b1;
            end
         end
         S_FLUSH: begin
            if (bus.halt_req) begin
               w_state = S_HALT;
               w_vld   = 1'b0;
            end else if (!bus.stall) begin
               w_fetch = 1'b1;
               w_state = S_RUN;
            end
         end
         S_HALT: ;
         default: w_state = S_IDLE;
      endcase
      if (w_fetch) begin
         w_inst = bus.inst_mem_data;
         w_vld  = 1'b1;
         w_pc   = r_pc + pc_width'(1);
      end
   end

   assign w_counting = (r_state == S_RUN) || (r_state == S_FLUSH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= LP_START;
         r_inst  <= '0;
         r_vld   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_pc    <= w_pc;
         r_inst  <= w_inst;
         r_vld   <= w_vld;
         if (w_counting && (r_cnt != '1)) r_cnt <= r_cnt + cnt_width'(1);
      end
   end

`ifdef PC_FETCH_JUMP_CNT_EN
   logic [7:0] r_jcnt;
   always_ff @(posedge clk) begin
      if (reset)                           r_jcnt <= '0;
      else if (w_jump_acc && r_jcnt != '1) r_jcnt <= r_jcnt + 8'd1;
   end
   assign bus.jump_count = r_jcnt;
`else
   logic w_unused_jump_acc;
   assign w_unused_jump_acc = w_jump_acc;
`endif

   assign bus.pc          = r_pc;
   assign bus.inst_out    = r_inst;
   assign bus.inst_valid  = r_vld;
   assign bus.halted      = (r_state == S_HALT);
   assign bus.cycle_count = r_cnt;
endmodule
